mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle MIPS controller FSM. It decodes opcode/funct from the instruction register and sequences the shared datapath one state per clock.
- It is the driving end of the ALU interface: it issues the 3-bit ALU op (Add 000, Sub 001, And 010, Or 011, Slt 100) and consumes the ALU zero flag to resolve beq.
- All memory, register-file and mux controls come from this block.

Parameters:
- ADD_OP, 3'b000, ALU add encoding
- SUB_OP, 3'b001, ALU subtract encoding
- AND_OP, 3'b010, ALU and encoding
- OR_OP, 3'b011, ALU or encoding
- SLT_OP, 3'b100, ALU set-less-than encoding

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- pc_en  output  1  PC load enable (pc_write | (branch & zero))
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = A register
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  output  3  ALU operation
- state_dbg  output  4  current state encoding

Behaviour:
- Single clock. State register updates on the rising edge of clk. rst is asynchronous and active-high and forces state to IF immediately.
- All outputs are Moore, decoded from state only. The single exception is pc_en, which also ANDs zero in the BEQ state.
- During reset, outputs take IF values. Any output not listed for a state is 0.
- Supported opcodes:
  - R-type 000000: funct add 100000, sub 100010, and 100100, or 100101, slt 101010
  - lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010
- State encodings (state_dbg) and per-state outputs:
  - IF (0): mem_read=1, i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00, pc_en=1. Next state ID.
  - ID (1): alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut).
    - Next state by opcode: R -> EX_R; lw/sw -> MEM_ADDR; addi/slti -> EX_I; beq -> BEQ; j -> JMP.
    - Any other opcode, or an R-type with an unsupported funct, -> IF. No architectural side effect.
  - EX_R (2): alu_src_a=1, alu_src_b=00. alu_op from funct: add -> ADD, sub -> SUB, and -> AND, or -> OR, slt -> SLT. Next state WB_R.
  - WB_R (3): reg_write=1, reg_dst=1, mem_to_reg=0. Next state IF.
  - MEM_ADDR (4): alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state MEM_RD for lw, MEM_WR for sw.
  - MEM_RD (5): mem_read=1, i_or_d=1. Next state WB_LW.
  - WB_LW (6): reg_write=1, reg_dst=0, mem_to_reg=1. Next state IF.
  - MEM_WR (7): mem_write=1, i_or_d=1. Next state IF.
  - EX_I (8): alu_src_a=1, alu_src_b=10, alu_op=ADD for addi, SLT for slti. Next state WB_I.
  - WB_I (9): reg_write=1, reg_dst=0, mem_to_reg=0. Next state IF.
  - BEQ (10): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_en=zero. Next state IF.
  - JMP (11): pc_src=10, pc_en=1. Next state IF.
  - Encodings 12-15 are illegal and go to IF on the next edge. Outputs in these states are all 0.
- Instruction latencies (cycles, counted from IF):
  - R-type 4, lw 5, sw 4, addi/slti 4, beq 3, j 3, unsupported 2.
- opcode and funct are sampled only in ID, EX_R, MEM_ADDR and EX_I. The IR is stable there because ir_write=1 only in IF.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Reset asserted mid-instruction: state goes to IF asynchronously. No partial register or memory write completes after rst rises.

Test Plan:
- Reset: hold rst=1 for 2 cycles, release -> state_dbg=0, ir_write=1, pc_en=1, alu_op=000. After 1 clk, state_dbg=1.
- R-type sub (opcode 000000, funct 100010) -> state sequence 0,1,2,3,0. In state 2, alu_op=001 and alu_src_b=00. In state 3, reg_write=1 and reg_dst=1.
- lw (100011) -> states 0,1,4,5,6,0. In state 5, mem_read=1 and i_or_d=1. In state 6, mem_to_reg=1 and reg_write=1. sw (101011) -> states 0,1,4,7,0 with mem_write=1 in state 7 only.
- beq (000100):
  - zero=1 in state 10 -> pc_en=1, pc_src=01, alu_op=001.
  - zero=0 -> pc_en=0.
  - Toggling zero in any other state never raises pc_en except in IF/JMP.
- slti (001010) -> alu_op=100 in state 8. addi -> alu_op=000. Both reach WB_I with reg_dst=0. Opcode 111111 -> states 0,1,0 with reg_write and mem_write never 1.
- Async reset: assert rst mid-cycle during state 5 -> state_dbg=0 before the next clk edge, mem_to_reg never 1 afterwards.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS controller: one FSM state per clock, Moore outputs except pc_en (beq zero qualify).
// Instruction latency 2-5 cycles from IF; no backpressure, the datapath always accepts one step per clock.
module mc_controller #(
  parameter logic [2:0] ADD_OP = 3'b000,
  parameter logic [2:0] SUB_OP = 3'b001,
  parameter logic [2:0] AND_OP = 3'b010,
  parameter logic [2:0] OR_OP  = 3'b011,
  parameter logic [2:0] SLT_OP = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_EX_R     = 4'd2;
  localparam logic [3:0] S_WB_R     = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_WB_LW    = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_EX_I     = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JMP      = 4'd11;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_J    = 6'b000010;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       funct_ok;
  logic [2:0] r_alu_op;
  logic       pc_write;
  logic       branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= next_state;
  end

  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = ADD_OP;
    case (funct)
      6'b100000: r_alu_op = ADD_OP;
      6'b100010: r_alu_op = SUB_OP;
      6'b100100: r_alu_op = AND_OP;
      6'b100101: r_alu_op = OR_OP;
      6'b101010: r_alu_op = SLT_OP;
      default:   funct_ok = 1'b0;
    endcase
  end

  // Unsupported opcodes and R-type functs fall back to IF with no side effect.
  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF: next_state = S_ID;
      S_ID: begin
        case (opcode)
          OPC_R:              next_state = funct_ok ? S_EX_R : S_IF;
          OPC_LW, OPC_SW:     next_state = S_MEM_ADDR;
          OPC_ADDI, OPC_SLTI: next_state = S_EX_I;
          OPC_BEQ:            next_state = S_BEQ;
          OPC_J:              next_state = S_JMP;
          default:            next_state = S_IF;
        endcase
      end
      S_EX_R:     next_state = S_WB_R;
      S_MEM_ADDR: next_state = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = S_WB_LW;
      S_EX_I:     next_state = S_WB_I;
      default:    next_state = S_IF;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ADD_OP;
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_ID: alu_src_b = 2'b11;
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OPC_SLTI) ? SLT_OP : ADD_OP;
      end
      S_WB_I: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = SUB_OP;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_JMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en     = pc_write | (branch & zero);
  assign state_dbg = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed instructions push expected per-cycle state/outputs,
// a negedge monitor pops and compares.
module tb_mc_controller;
  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  mc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .state_dbg(state_dbg)
  );

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   excl_viol = 0;
  int   m2r_viol = 0;
  logic post_arst = 1'b0;
  logic [15:0] act;

  assign act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_src, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written per-state output table:
  // {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,pc_src,alu_op}
  function automatic logic [15:0] ev(input logic [3:0] st, input logic [2:0] op, input logic pe);
    case (st)
      4'd0:  return 16'b1_0_1_0_1_0_0_0_0_01_00_000;
      4'd1:  return 16'b0_0_0_0_0_0_0_0_0_11_00_000;
      4'd2:  return {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, op};
      4'd3:  return 16'b0_0_0_0_0_1_0_1_0_00_00_000;
      4'd4:  return 16'b0_0_0_0_0_0_0_0_1_10_00_000;
      4'd5:  return 16'b0_1_1_0_0_0_0_0_0_00_00_000;
      4'd6:  return 16'b0_0_0_0_0_0_1_1_0_00_00_000;
      4'd7:  return 16'b0_1_0_1_0_0_0_0_0_00_00_000;
      4'd8:  return {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, op};
      4'd9:  return 16'b0_0_0_0_0_0_0_1_0_00_00_000;
      4'd10: return {pe, 8'b0_0_0_0_0_0_0_1, 2'b00, 2'b01, 3'b001};
      4'd11: return 16'b1_0_0_0_0_0_0_0_0_00_10_000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push(input string nm, input logic [3:0] st, input logic [2:0] op = 3'b000,
                      input logic pe = 1'b0);
    exp_t e;
    e.nm = nm;
    e.st = st;
    e.v  = ev(st, op, pe);
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [19:0] got, input logic [19:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got state/outs=%h, expected %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mem_read && mem_write) excl_viol++;
    if (reg_write && mem_write) excl_viol++;
    if (post_arst && mem_to_reg) m2r_viol++;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.nm, {state_dbg, act}, {e.st, e.v});
    end
  end

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d expected entries left, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  // Leaves the bench at posedge+1 of the next IF cycle.
  task automatic drain(input string nm);
    wait_empty(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    issue(6'b111111, 6'b000000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", {state_dbg, act}, {4'd0, ev(4'd0, 3'b000, 1'b0)});
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset release then R-type sub
    issue(6'b000000, 6'b100010, 1'b0);
    push("sub_if", 0); push("sub_id", 1); push("sub_ex", 2, 3'b001); push("sub_wb", 3);
    drain("sub");

    // Other R-type functs; zero held high must not raise pc_en outside IF
    issue(6'b000000, 6'b100000, 1'b1);
    push("add_if", 0); push("add_id", 1); push("add_ex", 2, 3'b000); push("add_wb", 3);
    drain("add");
    issue(6'b000000, 6'b100100, 1'b0);
    push("and_if", 0); push("and_id", 1); push("and_ex", 2, 3'b010); push("and_wb", 3);
    drain("and");
    issue(6'b000000, 6'b100101, 1'b1);
    push("or_if", 0); push("or_id", 1); push("or_ex", 2, 3'b011); push("or_wb", 3);
    drain("or");
    issue(6'b000000, 6'b101010, 1'b0);
    push("slt_if", 0); push("slt_id", 1); push("slt_ex", 2, 3'b100); push("slt_wb", 3);
    drain("slt");

    issue(6'b100011, 6'b000000, 1'b1);
    push("lw_if", 0); push("lw_id", 1); push("lw_addr", 4); push("lw_rd", 5); push("lw_wb", 6);
    drain("lw");
    issue(6'b101011, 6'b000000, 1'b0);
    push("sw_if", 0); push("sw_id", 1); push("sw_addr", 4); push("sw_wr", 7);
    drain("sw");

    issue(6'b000100, 6'b000000, 1'b1);
    push("beq_t_if", 0); push("beq_t_id", 1); push("beq_t_br", 10, 3'b001, 1'b1);
    drain("beq_taken");
    issue(6'b000100, 6'b000000, 1'b0);
    push("beq_n_if", 0); push("beq_n_id", 1); push("beq_n_br", 10, 3'b001, 1'b0);
    drain("beq_not_taken");

    issue(6'b001000, 6'b000000, 1'b1);
    push("addi_if", 0); push("addi_id", 1); push("addi_ex", 8, 3'b000); push("addi_wb", 9);
    drain("addi");
    issue(6'b001010, 6'b000000, 1'b0);
    push("slti_if", 0); push("slti_id", 1); push("slti_ex", 8, 3'b100); push("slti_wb", 9);
    drain("slti");

    issue(6'b000010, 6'b000000, 1'b0);
    push("j_if", 0); push("j_id", 1); push("j_jmp", 11);
    drain("j");

    issue(6'b111111, 6'b000000, 1'b1);
    push("badop_if", 0); push("badop_id", 1);
    drain("badop");
    issue(6'b000000, 6'b111111, 1'b0);
    push("badfn_if", 0); push("badfn_id", 1);
    drain("badfn");

    // Async reset in the middle of MEM_RD
    issue(6'b100011, 6'b000000, 1'b0);
    push("lwa_if", 0); push("lwa_id", 1); push("lwa_addr", 4); push("lwa_rd", 5);
    wait_empty("lw_abort");
    #1;
    rst = 1'b1;
    #1;
    check("arst_state", {16'h0000, state_dbg}, {16'h0000, 4'd0});
    check("arst_outs", {state_dbg, act}, {4'd0, ev(4'd0, 3'b000, 1'b0)});
    post_arst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(6'b111111, 6'b000000, 1'b0);
    push("post_if", 0); push("post_id", 1);
    drain("post_badop");
    issue(6'b000100, 6'b000000, 1'b1);
    push("post_beq_if", 0); push("post_beq_id", 1); push("post_beq_br", 10, 3'b001, 1'b1);
    wait_empty("post_beq");
    @(negedge clk);

    check("mem_excl_violations", {4'd0, 16'(excl_viol)}, 20'd0);
    check("mem_to_reg_after_arst", {4'd0, 16'(m2r_viol)}, 20'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation still running at 50000, required finish earlier");
    $fatal(1, "timeout");
  end

endmodule
